// File: rtl/gray_code_pkg.sv
// Shared types and helpers for the gray-code link receiver.
package gray_code_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam int DELTA_UP      = 1;
  localparam int GRAY_MAX_BITS = 32;

  // Narrower buses are zero-extended by the caller; leading zeros leave the low bits unchanged.
  function automatic logic [GRAY_MAX_BITS-1:0] gray2bin(input logic [GRAY_MAX_BITS-1:0] gray);
    logic [GRAY_MAX_BITS-1:0] bin;
    bin[GRAY_MAX_BITS-1] = gray[GRAY_MAX_BITS-1];
    for (int i = GRAY_MAX_BITS - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Combinational gray-to-binary decoder; inverse of the binary-to-gray encoder at the link source.
module gray_to_binary
  import gray_code_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] gray,
  output logic [BITS-1:0] bin
);

  assign bin = BITS'(gray2bin(GRAY_MAX_BITS'(gray)));

endmodule

// File: rtl/gray_code_receiver.sv
// Synchronises an asynchronous gray-coded bus, decodes it and classifies each change.
//   state | meaning
//   FILL  | synchroniser filling after reset; initial value captured on the last cycle
//   TRACK | locked; every change reported as step-up, step-down or error
module gray_code_receiver
  import gray_code_pkg::*;
#(
  parameter int BITS         = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int STALL_CYCLES = 32,
  parameter int STALL_BITS   = 6,
  parameter int ERR_BITS     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BITS-1:0]     gray_in,
  input  logic                err_clr,
  output logic [BITS-1:0]     value,
  output logic                locked,
  output logic                step_up,
  output logic                step_down,
  output logic                error,
  output logic [ERR_BITS-1:0] err_count,
  output logic                stalled
);

  localparam int FILL_BITS = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_BITS-1:0]  FILL_LOAD  = FILL_BITS'(SYNC_STAGES);
  localparam logic [STALL_BITS-1:0] STALL_LOAD = STALL_BITS'(STALL_CYCLES);

  state_t                state, state_nxt;
  logic [BITS-1:0]       sync_last, bin_now, delta, value_nxt;
  logic [FILL_BITS-1:0]  fill_left, fill_nxt;
  logic [STALL_BITS-1:0] stall_left, stall_nxt;
  logic [ERR_BITS-1:0]   err_cnt_nxt;
  logic                  locked_nxt, up_nxt, down_nxt, err_nxt;

  // A legal source flips one bit per step, so per-bit synchronisation cannot tear a word.
  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
    logic [BITS-1:0] q;
    if (s == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= gray_in;
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= g_sync[s-1].q;
      end
    end
  end

  assign sync_last = g_sync[SYNC_STAGES-1].q;

  gray_to_binary #(.BITS(BITS)) u_decode (
    .gray (sync_last),
    .bin  (bin_now)
  );

  assign delta = bin_now - value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    value_nxt   = value;
    locked_nxt  = locked;
    fill_nxt    = fill_left;
    stall_nxt   = stall_left;
    up_nxt      = 1'b0;
    down_nxt    = 1'b0;
    err_nxt     = 1'b0;
    // Clear first so a coinciding error still counts once.
    err_cnt_nxt = err_clr ? '0 : err_count;
    case (state)
      FILL: begin
        if (fill_left == '0) begin
          value_nxt  = bin_now;
          locked_nxt = 1'b1;
          state_nxt  = TRACK;
        end else begin
          fill_nxt = fill_left - FILL_BITS'(1);
        end
      end
      TRACK: begin
        if (delta == '0) begin
          if (stall_left != '0) stall_nxt = stall_left - STALL_BITS'(1);
        end else begin
          value_nxt = bin_now;
          stall_nxt = STALL_LOAD;
          if (delta == BITS'(DELTA_UP)) begin
            up_nxt = 1'b1;
          end else if (&delta) begin
            down_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
            if (~&err_cnt_nxt) err_cnt_nxt = err_cnt_nxt + ERR_BITS'(1);
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value      <= '0;
      locked     <= 1'b0;
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      error      <= 1'b0;
      err_count  <= '0;
      stalled    <= 1'b0;
      fill_left  <= FILL_LOAD;
      stall_left <= STALL_LOAD;
    end else begin
      value      <= value_nxt;
      locked     <= locked_nxt;
      step_up    <= up_nxt;
      step_down  <= down_nxt;
      error      <= err_nxt;
      err_count  <= err_cnt_nxt;
      stalled    <= (stall_nxt == '0);
      fill_left  <= fill_nxt;
      stall_left <= stall_nxt;
    end
  end

endmodule
